// File: rtl/crossbar_arbiter_2x2_pkg.sv
// Shared constants and helpers for the 2x2 crossbar arbiter.
// Crossbar select encoding, destination encoding and the grant bundle.
package crossbar_arbiter_2x2_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF  = 8;

    localparam logic CTRL_STRAIGHT = 1'b1;
    localparam logic CTRL_CROSS    = 1'b0;
    localparam logic DEST_OUT1     = 1'b0;
    localparam logic DEST_OUT2     = 1'b1;

    localparam logic PTR_IN1 = 1'b0;
    localparam logic PTR_IN2 = 1'b1;

    typedef struct packed {
        logic g2;
        logic g1;
    } grant_t;

    // Whenever in1 is granted its destination alone fixes the select;
    // otherwise only in2 can be steering the crossbar.
    function automatic logic ctrl_for(input grant_t g, input logic d1, input logic d2);
        if (g.g1)
            return (d1 == DEST_OUT1) ? CTRL_STRAIGHT : CTRL_CROSS;
        return (d2 == DEST_OUT2) ? CTRL_STRAIGHT : CTRL_CROSS;
    endfunction

endpackage

// File: rtl/crossbar_arbiter_2x2_rr_arb2.sv
// Two-request round-robin arbiter; the pointer names the source that
// wins the next tie and flips only when a tie is actually resolved.
module rr_arb2
    import crossbar_arbiter_2x2_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (ptr_q == PTR_IN1) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (update_i && (req_i == 2'b11))
            ptr_d = ~ptr_q;
    end

    // NOTE: state registers use non-blocking assignment so all flops
    // sample together at the edge regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= PTR_IN1;
        else
            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/crossbar_arbiter_2x2.sv
// Arbitrates two sources onto a registered 2x2 crossbar stage and counts
// same-destination conflicts; the crossbar itself lives in the parent.
module crossbar_arbiter_2x2
    import crossbar_arbiter_2x2_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in1_valid,
    input  logic              in1_dest,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    input  logic              in2_valid,
    input  logic              in2_dest,
    input  logic [DATA_W-1:0] in2_data,
    output logic              in2_ready,
    output logic [DATA_W-1:0] xbar_in1,
    output logic [DATA_W-1:0] xbar_in2,
    output logic              xbar_control,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic              out2_valid,
    input  logic              out2_ready,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              out1_valid_q, out1_valid_d;
    logic              out2_valid_q, out2_valid_d;
    logic [DATA_W-1:0] xbar_in1_q, xbar_in1_d;
    logic [DATA_W-1:0] xbar_in2_q, xbar_in2_d;
    logic              ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic       stage_free;
    logic       conflict;
    logic [1:0] arb_gnt;
    grant_t     grant;

    assign stage_free = (!out1_valid_q || out1_ready) && (!out2_valid_q || out2_ready);
    assign conflict   = in1_valid && in2_valid && (in1_dest == in2_dest);

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({in2_valid, in1_valid}),
        .update_i (conflict && stage_free),
        .gnt_o    (arb_gnt)
    );

    // The arbiter only matters on a tie; distinct destinations both pass.
    assign grant.g1 = conflict ? arb_gnt[0] : in1_valid;
    assign grant.g2 = conflict ? arb_gnt[1] : in2_valid;

    assign in1_ready = stage_free && grant.g1 && !rst;
    assign in2_ready = stage_free && grant.g2 && !rst;

    always_comb begin
        out1_valid_d = out1_valid_q;
        out2_valid_d = out2_valid_q;
        xbar_in1_d   = xbar_in1_q;
        xbar_in2_d   = xbar_in2_q;
        ctrl_d       = ctrl_q;
        cnt_d        = cnt_q;
        if (stage_free) begin
            out1_valid_d = (grant.g1 && in1_dest == DEST_OUT1) || (grant.g2 && in2_dest == DEST_OUT1);
            out2_valid_d = (grant.g1 && in1_dest == DEST_OUT2) || (grant.g2 && in2_dest == DEST_OUT2);
            if (grant.g1 || grant.g2) begin
                xbar_in1_d = grant.g1 ? in1_data : '0;
                xbar_in2_d = grant.g2 ? in2_data : '0;
                ctrl_d     = ctr_sel(grant, in1_dest, in2_dest);
            end
            if (conflict && (cnt_q != {CNT_W{1'b1}}))
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    function automatic logic ctr_sel(input grant_t g, input logic d1, input logic d2);
        return ctrl_for(g, d1, d2);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            out1_valid_q <= 1'b0;
            out2_valid_q <= 1'b0;
            xbar_in1_q   <= '0;
            xbar_in2_q   <= '0;
            ctrl_q       <= CTRL_STRAIGHT;
            cnt_q        <= '0;
        end else begin
            out1_valid_q <= out1_valid_d;
            out2_valid_q <= out2_valid_d;
            xbar_in1_q   <= xbar_in1_d;
            xbar_in2_q   <= xbar_in2_d;
            ctrl_q       <= ctrl_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out1_valid   = out1_valid_q;
    assign out2_valid   = out2_valid_q;
    assign xbar_in1     = xbar_in1_q;
    assign xbar_in2     = xbar_in2_q;
    assign xbar_control = ctrl_q;
    assign conflict_cnt = cnt_q;

endmodule
